// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers
module fifo_read_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                fifo_empty,
  output logic                fifo_ren,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                pop,
  output logic                busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [ID_WIDTH-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 owner_req, last, rel;
  logic [ID_WIDTH-1:0]  nxt_ptr;
  logic [ID_WIDTH:0]    win;
  // returns {found, index} of the first set bit of cand scanning upward from ptr, wrapping
  function automatic logic [ID_WIDTH:0] pick(input logic [NUM_REQ-1:0] cand, input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0] idx;
    logic [ID_WIDTH:0] res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      if (cand[idx[ID_WIDTH-1:0]]) res = {1'b1, idx[ID_WIDTH-1:0]};
    end
    return res;
  endfunction
  assign busy      = state_q == BURST;
  assign owner_req = req[gnt_id_q];
  assign pop       = busy & owner_req & ~fifo_empty;
  assign fifo_ren  = pop;
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign last      = burst_cnt_q == CNT_WIDTH'(MAX_BURST - 1);
  assign rel       = ~owner_req | (pop & last);
  assign nxt_ptr   = (gnt_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
  // a dropped owner already has req[gnt_id]=0, so raw req is the masked candidate set
  assign win       = pick(req, busy ? nxt_ptr : rr_ptr_q);
  // next-state: arbitrate when idle or on release, otherwise count pops within the burst
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (!busy || rel) begin
      rr_ptr_d    = busy ? nxt_ptr : rr_ptr_q;
      state_d     = win[ID_WIDTH] ? BURST : IDLE;
      gnt_id_d    = win[ID_WIDTH] ? win[ID_WIDTH-1:0] : gnt_id_q;
      burst_cnt_d = '0;
    end else if (pop) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
    gnt_d = (state_d == BURST) ? NUM_REQ'(1) << gnt_id_d : '0;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed self-checking bench for fifo_read_arbiter
module tb_fifo_read_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       fifo_empty;
  logic       fifo_ren;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       pop;
  logic       busy;
  int tests = 0;
  int fails = 0;
  fifo_read_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .gnt(gnt), .gnt_id(gnt_id), .pop(pop), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ren"}, 32'(fifo_ren), 32'h0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    fifo_empty = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int pops;
    int cnt_exp [1:8];
    rst = 1'b0;
    req = '0;
    fifo_empty = 1'b0;
    #1;
    idle_chk("rst0");
    cyc();
    idle_chk("rst1");
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      idle_chk("idle");
    end
    do_reset();
    req = 4'b0100;
    #1;
    chk("single_lat_gnt", 32'(gnt), 32'h0);
    pops = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_id", 32'(gnt_id), 32'h2);
      chk("single_pop", 32'(pop), 32'h1);
      chk("single_cnt", 32'(dut.burst_cnt_q), 32'((c - 1) % 4));
      if (pop) pops++;
      if (c == 5) chk("single_rrptr", 32'(dut.rr_ptr_q), 32'h3);
      if (c == 8) chk("single_pops8", 32'(pops), 32'd8);
    end
    rst = 1'b0;
    #1;
    idle_chk("midrst");
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      chk("rr_id", 32'(gnt_id), 32'(((c - 1) / 4) % 4));
      chk("rr_gnt", 32'(gnt), 32'(1 << (((c - 1) / 4) % 4)));
      chk("rr_pop", 32'(pop), 32'h1);
    end
    do_reset();
    cnt_exp = '{0, 1, 2, 2, 2, 2, 3, 0};
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      fifo_empty = (c >= 3 && c <= 5);
      #1;
      chk("stall_gnt", 32'(gnt), 32'h2);
      chk("stall_ren", 32'(fifo_ren), 32'(!(c >= 3 && c <= 5)));
      chk("stall_cnt", 32'(dut.burst_cnt_q), 32'(cnt_exp[c]));
      chk("stall_noren_empty", 32'(fifo_ren & fifo_empty), 32'h0);
    end
    chk("stall_rrptr", 32'(dut.rr_ptr_q), 32'h2);
    do_reset();
    req = 4'b1001;
    cyc();
    chk("drop_gnt0", 32'(gnt), 32'h1);
    chk("drop_pop0", 32'(pop), 32'h1);
    cyc();
    req = 4'b1000;
    #1;
    chk("drop_ren", 32'(fifo_ren), 32'h0);
    chk("drop_gnt_hold", 32'(gnt), 32'h1);
    cyc();
    chk("drop_gnt3", 32'(gnt), 32'h8);
    chk("drop_id3", 32'(gnt_id), 32'h3);
    chk("drop_pop3", 32'(pop), 32'h1);
    cyc();
    req = 4'b1010;
    #1;
    chk("wrap_cnt1", 32'(dut.burst_cnt_q), 32'h1);
    cyc();
    chk("wrap_cnt2", 32'(dut.burst_cnt_q), 32'h2);
    cyc();
    chk("wrap_cnt3", 32'(dut.burst_cnt_q), 32'h3);
    chk("wrap_pop3", 32'(pop), 32'h1);
    cyc();
    chk("wrap_gnt", 32'(gnt), 32'h2);
    chk("wrap_id", 32'(gnt_id), 32'h1);
    chk("wrap_rrptr", 32'(dut.rr_ptr_q), 32'h0);
    chk("wrap_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    cyc();
    idle_chk("final_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
